// File: rtl/tpu_issue_receiver_pkg.sv
// Shared types and sizes for the TPU issue receiver: bank status, FSM
// encodings, per-bank descriptor and the derived address/length widths.
package tpu_issue_receiver_pkg;

  localparam int WIDTH_INSTR     = 32;
  localparam int DEPTH_BANK      = 64;
  localparam int WIDTH_NUM_ISSUE = 8;
  localparam int WIDTH_ISSUE     = WIDTH_NUM_ISSUE;
  localparam int ADDR_W          = $clog2(DEPTH_BANK);
  localparam int LEN_W           = ADDR_W + 1;

  typedef logic [WIDTH_INSTR-1:0] instr_t;
  typedef logic [WIDTH_ISSUE-1:0] issue_t;
  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [LEN_W-1:0]       len_t;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2,
    BANK_RUNNING = 2'd3
  } bank_st_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    RUN_IDLE   = 2'd0,
    RUN_RUN    = 2'd1,
    RUN_COMMIT = 2'd2
  } run_state_e;

  typedef struct packed {
    len_t   length;
    issue_t issue_no;
  } bank_desc_t;

  // Beat counter increment that stops at a full bank.
  function automatic len_t len_inc_sat(len_t l);
    return (l == len_t'(DEPTH_BANK)) ? l : l + len_t'(1);
  endfunction

endpackage

// File: rtl/tpu_issue_receiver_if.sv
// Bus bundle between the MPU dispatcher / TPU sequencer (master) and the
// issue receiver (slave).
//
// Handshake semantics: the MPU may begin a burst only in a cycle where
// O_Ready=1; a burst is a run of consecutive I_Req=1 cycles (each one beat,
// qualified by I_En) with I_IssueNo stable, terminated by the first cycle with
// I_Req=0. There is no per-beat backpressure. O_Start and O_Req_Commit are
// single-cycle pulses with no acknowledge; I_End_Exe is a single-cycle pulse
// from the sequencer and only has meaning while a thread is running.
interface tpu_issue_receiver_if;
  import tpu_issue_receiver_pkg::*;

  logic   I_En;
  logic   I_Req;
  instr_t I_Instr;
  issue_t I_IssueNo;
  logic   O_Ready;
  logic   O_Start;
  logic   O_Bank;
  len_t   O_Length;
  addr_t  I_Rd_Addr;
  instr_t O_Rd_Instr;
  logic   I_End_Exe;
  logic   O_Req_Commit;
  issue_t O_CommitNo;
  logic   O_Err;

  modport master (
    output I_En, I_Req, I_Instr, I_IssueNo, I_Rd_Addr, I_End_Exe,
    input  O_Ready, O_Start, O_Bank, O_Length, O_Rd_Instr, O_Req_Commit,
           O_CommitNo, O_Err
  );

  modport slave (
    input  I_En, I_Req, I_Instr, I_IssueNo, I_Rd_Addr, I_End_Exe,
    output O_Ready, O_Start, O_Bank, O_Length, O_Rd_Instr, O_Req_Commit,
           O_CommitNo, O_Err
  );

endinterface

// File: rtl/tpu_issue_receiver_instr_bank.sv
// Double-banked instruction store: one write port, one registered read
// port, 2*DEPTH_BANK words addressed by {bank, addr}.
module tpu_instr_bank
  import tpu_issue_receiver_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [ADDR_W:0] wr_addr,
  input  instr_t        wr_data,
  input  logic [ADDR_W:0] rd_addr,
  output instr_t        rd_data
);

  instr_t mem [2*DEPTH_BANK];

  // Storage array: written on each accepted beat, never reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register: one-cycle fetch latency, cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tpu_issue_receiver.sv
// TPU-side endpoint of the MPU issue/commit protocol. Bursts are received
// into one of two banks while the other may be running; threads start and
// commit in receive order.
// Optional build macro: TPU_RCV_PROTOCOL_CHECK_EN (drop beats past a full
// bank instead of wrapping, and raise a sticky O_Err on protocol misuse).
module tpu_issue_receiver
  import tpu_issue_receiver_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  tpu_issue_receiver_if.slave  bus,
  output rx_state_e            dbg_rx_state,
  output run_state_e           dbg_run_state
);

  rx_state_e  rx_state;
  run_state_e run_state;
  bank_st_e   st     [2];
  bank_st_e   st_nxt [2];
  bank_desc_t desc   [2];

  logic   fill_ptr, run_ptr;
  addr_t  wr_ptr;
  len_t   cnt;

  logic   ready_q, start_q, bank_q, commit_q;
  len_t   len_q;
  issue_t commit_no_q;
  instr_t rd_q;

  logic      burst_start, burst_end, beat_in_burst, beat_keep;
  logic      run_go, commit_done;
  logic      wr_en;
  addr_t     wr_addr;
  logic      fill_nxt;
  rx_state_e rx_nxt;

  // Protocol events decoded from the current FSM states and the bus.
  always_comb begin
    burst_start   = (rx_state == RX_IDLE) && bus.I_Req && bus.I_En && ready_q;
    beat_in_burst = (rx_state == RX_RECV) && bus.I_Req && bus.I_En;
`ifdef TPU_RCV_PROTOCOL_CHECK_EN
    beat_keep     = beat_in_burst && (cnt != len_t'(DEPTH_BANK));
`else
    beat_keep     = beat_in_burst;
`endif
    burst_end     = (rx_state == RX_RECV) && !bus.I_Req;
    run_go        = (run_state == RUN_IDLE) && (st[run_ptr] == BANK_READY);
    commit_done   = (run_state == RUN_COMMIT);
    wr_en         = burst_start || beat_keep;
    wr_addr       = burst_start ? '0 : wr_ptr;
    fill_nxt      = burst_end ? ~fill_ptr : fill_ptr;
    rx_nxt        = burst_start ? RX_RECV : (burst_end ? RX_IDLE : rx_state);
  end

  // Next bank status: fill and run sides always touch different banks.
  always_comb begin
    st_nxt[0] = st[0];
    st_nxt[1] = st[1];
    if (burst_start) st_nxt[fill_ptr] = BANK_FILLING;
    if (burst_end)   st_nxt[fill_ptr] = BANK_READY;
    if (run_go)      st_nxt[run_ptr]  = BANK_RUNNING;
    if (commit_done) st_nxt[run_ptr]  = BANK_FREE;
  end

  // Bank status table and the registered ready flag derived from it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st[0]   <= BANK_FREE;
      st[1]   <= BANK_FREE;
      ready_q <= 1'b0;
    end else begin
      st[0]   <= st_nxt[0];
      st[1]   <= st_nxt[1];
      ready_q <= (st_nxt[fill_nxt] == BANK_FREE) && (rx_nxt == RX_IDLE);
    end
  end

  // Receive FSM: write pointer, beat count and the filling bank's descriptor.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      fill_ptr <= 1'b0;
      wr_ptr   <= '0;
      cnt      <= '0;
      desc[0]  <= '0;
      desc[1]  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (burst_start) begin
            rx_state                <= RX_RECV;
            wr_ptr                  <= addr_t'(1);
            cnt                     <= len_t'(1);
            desc[fill_ptr].issue_no <= bus.I_IssueNo;
          end
        end
        RX_RECV: begin
          if (burst_end) begin
            rx_state              <= RX_IDLE;
            desc[fill_ptr].length <= cnt;
            fill_ptr              <= ~fill_ptr;
          end else if (beat_keep) begin
            wr_ptr <= wr_ptr + addr_t'(1);
            cnt    <= len_inc_sat(cnt);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Run FSM: start pulse, running-thread info and the one-cycle commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_state   <= RUN_IDLE;
      run_ptr     <= 1'b0;
      start_q     <= 1'b0;
      bank_q      <= 1'b0;
      len_q       <= '0;
      commit_q    <= 1'b0;
      commit_no_q <= '0;
    end else begin
      start_q  <= 1'b0;
      commit_q <= 1'b0;
      case (run_state)
        RUN_IDLE: begin
          if (run_go) begin
            run_state <= RUN_RUN;
            start_q   <= 1'b1;
            bank_q    <= run_ptr;
            len_q     <= desc[run_ptr].length;
          end
        end
        RUN_RUN: begin
          if (bus.I_End_Exe) begin
            run_state   <= RUN_COMMIT;
            commit_q    <= 1'b1;
            commit_no_q <= desc[run_ptr].issue_no;
          end
        end
        RUN_COMMIT: begin
          run_state   <= RUN_IDLE;
          commit_no_q <= '0;
          run_ptr     <= ~run_ptr;
        end
        default: run_state <= RUN_IDLE;
      endcase
    end
  end

`ifdef TPU_RCV_PROTOCOL_CHECK_EN
  logic err_q;
  logic violation;

  // Misuse: beats while not ready, issue number change mid-burst, overflow.
  always_comb begin
    violation = ((rx_state == RX_IDLE) && bus.I_Req && bus.I_En && !ready_q) ||
                (beat_in_burst && (bus.I_IssueNo != desc[fill_ptr].issue_no)) ||
                (beat_in_burst && !beat_keep);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         err_q <= 1'b0;
    else if (violation) err_q <= 1'b1;
  end

  assign bus.O_Err = err_q;
`else
  assign bus.O_Err = 1'b0;
`endif

  tpu_instr_bank u_bank (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr ({fill_ptr, wr_addr}),
    .wr_data (bus.I_Instr),
    .rd_addr ({bank_q, bus.I_Rd_Addr}),
    .rd_data (rd_q)
  );

  assign bus.O_Ready      = ready_q;
  assign bus.O_Start      = start_q;
  assign bus.O_Bank       = bank_q;
  assign bus.O_Length     = len_q;
  assign bus.O_Rd_Instr   = rd_q;
  assign bus.O_Req_Commit = commit_q;
  assign bus.O_CommitNo   = commit_no_q;
  assign dbg_rx_state     = rx_state;
  assign dbg_run_state    = run_state;

endmodule

// File: tb/tb_tpu_issue_receiver.sv
// Directed bench for tpu_issue_receiver: bursts, start/read/commit timing,
// overflow, dropped bursts and reset in flight.
module tb_tpu_issue_receiver;
  import tpu_issue_receiver_pkg::*;

  logic       clock;
  logic       reset;
  rx_state_e  dbg_rx_state;
  run_state_e dbg_run_state;

  tpu_issue_receiver_if bus();

  tpu_issue_receiver dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .dbg_rx_state  (dbg_rx_state),
    .dbg_run_state (dbg_run_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH_ISSUE-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_burst(input logic [WIDTH_ISSUE-1:0] issue, input int n,
                            input logic [31:0] base, input logic en);
    bus.I_En      = en;
    bus.I_IssueNo = issue;
    for (int i = 0; i < n; i++) begin
      bus.I_Req   = 1'b1;
      bus.I_Instr = base + 32'(i);
      cycle();
    end
    bus.I_Req   = 1'b0;
    bus.I_Instr = '0;
    cycle();
    bus.I_En = 1'b1;
  endtask

  task automatic check_start(input string tag, input logic bank, input int len);
    check({tag, "_start"}, 64'(bus.O_Start), 64'(1));
    check({tag, "_bank"},  64'(bus.O_Bank),  64'(bank));
    check({tag, "_len"},   64'(bus.O_Length), 64'(len));
  endtask

  task automatic check_read(input string tag, input int addr, input logic [31:0] exp);
    bus.I_Rd_Addr = addr_t'(addr);
    cycle();
    check(tag, 64'(bus.O_Rd_Instr), 64'(exp));
  endtask

  // Pulse end-of-execution and check the commit against the expected queue.
  task automatic end_thread(input string tag);
    logic [WIDTH_ISSUE-1:0] exp_no;
    exp_no = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    bus.I_End_Exe = 1'b1;
    cycle();
    bus.I_End_Exe = 1'b0;
    check({tag, "_req"}, 64'(bus.O_Req_Commit), 64'(1));
    check({tag, "_no"},  64'(bus.O_CommitNo),   64'(exp_no));
    cycle();
    check({tag, "_pulse1"}, 64'(bus.O_Req_Commit), 64'(0));
  endtask

  // Nothing may start or commit during the window.
  task automatic watch_quiet(input string tag, input int n);
    int starts, commits;
    starts  = 0;
    commits = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      bus.I_End_Exe = 1'b0;
      if (bus.O_Start)      starts++;
      if (bus.O_Req_Commit) commits++;
    end
    check({tag, "_starts"},  64'(starts),  64'(0));
    check({tag, "_commits"}, 64'(commits), 64'(0));
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [31:0] exp_w;
    reset         = 1'b0;
    bus.I_En      = 1'b1;
    bus.I_Req     = 1'b0;
    bus.I_Instr   = '0;
    bus.I_IssueNo = '0;
    bus.I_Rd_Addr = '0;
    bus.I_End_Exe = 1'b0;
    cycle();
    cycle();

    // Reset values
    check("rst_ready",  64'(bus.O_Ready),      64'(0));
    check("rst_start",  64'(bus.O_Start),      64'(0));
    check("rst_commit", 64'(bus.O_Req_Commit), 64'(0));
    check("rst_rd",     64'(bus.O_Rd_Instr),   64'(0));
    check("rst_err",    64'(bus.O_Err),        64'(0));
    reset = 1'b1;
    cycle();
    check("ready_after_rst", 64'(bus.O_Ready), 64'(1));

    // T1: 3-beat burst, issue 5, bank 0
    exp_q.push_back(8'd5);
    send_burst(8'd5, 3, 32'hA0, 1'b1);
    check("t1_ready_next_free", 64'(bus.O_Ready), 64'(1));
    cycle();
    check_start("t1", 1'b0, 3);
    cycle();
    check("t1_start_pulse1", 64'(bus.O_Start), 64'(0));
    for (int i = 0; i < 3; i++) check_read("t1_rd", i, 32'hA0 + 32'(i));
    end_thread("t1_commit");

    // T2: issue 1 (4 beats, bank 1) then issue 2 (2 beats, bank 0) while 1 runs
    exp_q.push_back(8'd1);
    send_burst(8'd1, 4, 32'hB0, 1'b1);
    cycle();
    check_start("t2a", 1'b1, 4);
    exp_q.push_back(8'd2);
    send_burst(8'd2, 2, 32'hC0, 1'b1);
    check("t2_ready_full", 64'(bus.O_Ready), 64'(0));
    cycle();
    check("t2_no_start_busy", 64'(bus.O_Start), 64'(0));

    // T3: third burst while both banks occupied is dropped
    send_burst(8'd7, 3, 32'hD0, 1'b1);
    check("t3_ready_full", 64'(bus.O_Ready), 64'(0));
`ifdef TPU_RCV_PROTOCOL_CHECK_EN
    check("t3_err", 64'(bus.O_Err), 64'(1));
`else
    check("t3_err", 64'(bus.O_Err), 64'(0));
`endif
    bus.I_End_Exe = 1'b1;
    cycle();
    bus.I_End_Exe = 1'b0;
    check("t2a_commit_req", 64'(bus.O_Req_Commit), 64'(1));
    check("t2a_commit_no",  64'(bus.O_CommitNo),   64'(exp_q.pop_front()));
    cycle();
    check("t2a_commit_pulse1", 64'(bus.O_Req_Commit), 64'(0));
    check("t2_ready_after_commit", 64'(bus.O_Ready), 64'(1));
    cycle();
    check_start("t2b", 1'b0, 2);
    check_read("t2b_rd0", 0, 32'hC0);
    check_read("t2b_rd1", 1, 32'hC1);
    end_thread("t2b_commit");
    watch_quiet("t3_dropped", 8);

    // T4: I_En=0 burst and a stray I_End_Exe are both ignored
    send_burst(8'd3, 3, 32'hF0, 1'b0);
    check("t4_ready", 64'(bus.O_Ready), 64'(1));
    bus.I_End_Exe = 1'b1;
    watch_quiet("t4_en0", 6);

    // T5: 70-beat burst into bank 1
    exp_q.push_back(8'h33);
    send_burst(8'h33, 70, 32'h1000, 1'b1);
    cycle();
    check_start("t5", 1'b1, 64);
    for (int i = 0; i < 7; i++) begin
`ifdef TPU_RCV_PROTOCOL_CHECK_EN
      exp_w = 32'h1000 + 32'(i);
`else
      exp_w = (i < 6) ? 32'h1000 + 32'(64 + i) : 32'h1000 + 32'(i);
`endif
      check_read("t5_rd", i, exp_w);
    end
`ifdef TPU_RCV_PROTOCOL_CHECK_EN
    check("t5_err", 64'(bus.O_Err), 64'(1));
`else
    check("t5_err", 64'(bus.O_Err), 64'(0));
`endif
    end_thread("t5_commit");

    // T6: reset during a running thread and an open burst
    exp_q.push_back(8'h44);
    send_burst(8'h44, 3, 32'h200, 1'b1);
    cycle();
    check_start("t6a", 1'b0, 3);
    bus.I_IssueNo = 8'h55;
    bus.I_Req     = 1'b1;
    bus.I_Instr   = 32'h300;
    cycle();
    bus.I_Instr   = 32'h301;
    cycle();
    check("t6_mid_rx", 64'(dbg_rx_state), 64'(RX_RECV));
    reset     = 1'b0;
    bus.I_Req = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_ready",  64'(bus.O_Ready),      64'(0));
    check("t6_rst_start",  64'(bus.O_Start),      64'(0));
    check("t6_rst_bank",   64'(bus.O_Bank),       64'(0));
    check("t6_rst_len",    64'(bus.O_Length),     64'(0));
    check("t6_rst_rd",     64'(bus.O_Rd_Instr),   64'(0));
    check("t6_rst_commit", 64'(bus.O_Req_Commit), 64'(0));
    check("t6_rst_cno",    64'(bus.O_CommitNo),   64'(0));
    check("t6_rst_err",    64'(bus.O_Err),        64'(0));
    check("t6_rst_rx",     64'(dbg_rx_state),     64'(RX_IDLE));
    check("t6_rst_run",    64'(dbg_run_state),    64'(RUN_IDLE));
    cycle();
    reset = 1'b1;
    cycle();
    check("t6_ready_after_rst", 64'(bus.O_Ready), 64'(1));
    exp_q.push_back(8'd9);
    send_burst(8'd9, 2, 32'hE0, 1'b1);
    cycle();
    check_start("t6b", 1'b0, 2);
    check_read("t6b_rd0", 0, 32'hE0);
    end_thread("t6b_commit");
    watch_quiet("t6_no_stale", 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_issue_receiver.md
Name: tpu_issue_receiver

Overview:
TPU-side endpoint of the MPU issue/commit protocol. It accepts instruction bursts (valid, instruction, issue number) from the MPU dispatcher and stores them in a double-banked local instruction buffer, so one thread can be received while the previous one runs. It hands ready threads to the TPU sequencer in order. When the sequencer signals completion, it returns a one-cycle commit (request plus issue number) to the MPU commit unit.

Parameters:
WIDTH_INSTR, 32, instruction word width
DEPTH_BANK, 64, instruction words per bank (power of 2)
WIDTH_ISSUE, 8, issue/commit number width (equals the MPU WIDTH_NUM_ISSUE)

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-low reset
I_En  in  1  this TPU is selected by the MPU TPU-enable vector
I_Req  in  1  instruction beat valid; a burst is consecutive high cycles
I_Instr  in  WIDTH_INSTR  instruction beat
I_IssueNo  in  WIDTH_ISSUE  issue number; held stable for the whole burst
O_Ready  out  1  a free bank exists; the MPU may start a burst
O_Start  out  1  one-cycle pulse: thread ready to execute
O_Bank  out  1  bank index of the running thread
O_Length  out  $clog2(DEPTH_BANK)+1  instruction count of the running thread
I_Rd_Addr  in  $clog2(DEPTH_BANK)  sequencer fetch address within O_Bank
O_Rd_Instr  out  WIDTH_INSTR  fetched instruction; 1-cycle read latency
I_End_Exe  in  1  sequencer pulse: running thread finished
O_Req_Commit  out  1  one-cycle commit request to the MPU
O_CommitNo  out  WIDTH_ISSUE  issue number being committed
O_Err  out  1  sticky protocol error (only with the optional feature)

Behaviour:
- Reset (async, active-low): all outputs 0; both banks FREE; fill pointer and run pointer 0; write pointer 0; FSMs IDLE. O_Ready rises on the first clock after reset release.
- Bank status per bank: FREE -> FILLING -> READY -> RUNNING -> FREE. Each bank records its length and issue number.
- Receive FSM:
  - IDLE -> RECV when I_Req & I_En and bank[fill_ptr] is FREE.
  - The first beat is written in the same cycle. Issue number is latched; write pointer becomes 1.
  - RECV: each I_Req cycle writes at the write pointer, then increments it.
  - Burst ends on the first cycle with I_Req=0. Bank becomes READY with length = beat count; fill_ptr toggles; FSM returns to IDLE.
  - Back-to-back bursts require at least one idle cycle between them.
- O_Ready = bank[fill_ptr] is FREE and the receive FSM is IDLE. It is registered and updates the cycle after any status change.
- Beats with I_En=0 are ignored. Beats arriving while O_Ready=0 (protocol violation) are dropped.
- Run FSM:
  - IDLE -> RUN when bank[run_ptr] is READY. O_Start pulses for 1 cycle; O_Bank and O_Length are valid from the O_Start cycle until commit. Bank becomes RUNNING.
  - RUN -> COMMIT on I_End_Exe.
  - COMMIT (1 cycle): O_Req_Commit=1 and O_CommitNo = bank issue number. Bank becomes FREE and run_ptr toggles. FSM returns to IDLE next cycle.
  - Minimum turnaround from one commit to the next O_Start is 1 cycle.
- Ordering: threads start and commit strictly in receive order.
- I_End_Exe is ignored outside RUN.
- Simultaneous events: a burst ending on bank A in the same cycle bank B commits is allowed. Both status updates apply. O_Ready reflects the freed bank the next cycle.
- A burst ending in the same cycle its bank could start: the start occurs the following cycle (READY must be registered first).
- Read port: O_Rd_Instr <= bank[O_Bank][I_Rd_Addr], registered. Reading at or beyond O_Length returns stale data.
- Overflow: a burst longer than DEPTH_BANK wraps the write pointer, overwriting from address 0. Length saturates at DEPTH_BANK.

Optional Feature:
- Macro: TPU_RCV_PROTOCOL_CHECK_EN.
- When defined:
  - Beats beyond DEPTH_BANK are dropped rather than wrapped.
  - Beats arriving while O_Ready=0 set O_Err.
  - A change of I_IssueNo mid-burst sets O_Err.
  - O_Err is sticky until reset.
- When not defined: O_Err is tied to 0; wrap behaviour applies; no checking logic is present.

Decomposition:
- Shared package pkg_tpu:
  - bank status enum (FREE/FILLING/READY/RUNNING)
  - receive and run FSM enums
  - bank descriptor struct (length, issue_no)
  - WIDTH_ISSUE tied to WIDTH_NUM_ISSUE
  - instr_t reused
- One sub-module: tpu_instr_bank, a 1-write/1-read synchronous RAM of 2*DEPTH_BANK words, addressed by {bank, addr}. It is instantiated once; control logic stays in the top.

Test Plan:
- Reset release, 3-beat burst (0xA0, 0xA1, 0xA2, IssueNo=5) -> O_Start one cycle after READY, O_Length=3. Reads at addr 0..2 return 0xA0..0xA2 one cycle later. I_End_Exe -> O_Req_Commit=1 with O_CommitNo=5 for exactly 1 cycle.
- Two bursts (IssueNo 1 len 4, IssueNo 2 len 2) sent while thread 1 runs -> bank 1 fills concurrently. O_Ready=0 after the second burst. Commits appear in order 1 then 2; O_Ready=1 the cycle after the first commit.
- Third burst attempted while both banks are occupied -> beats dropped and no commit for it. With TPU_RCV_PROTOCOL_CHECK_EN, O_Err=1 and stays high.
- I_En=0 burst -> no write, no O_Start, O_Ready unchanged.
- 70-beat burst with DEPTH_BANK=64 -> without the macro, addr 0..5 hold beats 64..69 and O_Length=64. With the macro, addr 0..5 hold beats 0..5 and O_Err=1.
- Reset asserted mid-burst and mid-RUN -> all outputs 0 immediately. After release, a fresh burst with IssueNo=9 commits 9; no stale commit is emitted.
